// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the time-shared 4-bit ALU.
//   DW         - datapath width
//   OP_*       - 4-bit opcode encodings
//   state_e    - arbitration/control FSM states
package alu_pkg;
  localparam int DW = 4;

  localparam logic [3:0] OP_OR_RED  = 4'd0;
  localparam logic [3:0] OP_AND_RED = 4'd1;
  localparam logic [3:0] OP_XOR_RED = 4'd2;
  localparam logic [3:0] OP_LNOT    = 4'd3;
  localparam logic [3:0] OP_ADD     = 4'd4;
  localparam logic [3:0] OP_MINUS   = 4'd5;
  localparam logic [3:0] OP_MUL     = 4'd6;
  localparam logic [3:0] OP_SHR     = 4'd7;
  localparam logic [3:0] OP_SHL     = 4'd8;
  localparam logic [3:0] OP_EQ      = 4'd9;
  localparam logic [3:0] OP_GT      = 4'd10;
  localparam logic [3:0] OP_LT      = 4'd11;
  localparam logic [3:0] OP_OR      = 4'd12;
  localparam logic [3:0] OP_AND     = 4'd13;
  localparam logic [3:0] OP_XOR     = 4'd14;
  localparam logic [3:0] OP_NOT_OP  = 4'd15;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;
endpackage

// File: rtl/alu_datapath.sv
// alu_datapath: purely combinational 4-bit ALU.
//   opcode, a, b : operation and operands
//   x, y         : result low / high nibble (every opcode fully defined)
module alu_datapath
  import alu_pkg::*;
(
  input  logic [DW-1:0] opcode,
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  output logic [DW-1:0] x,
  output logic [DW-1:0] y
);
  logic [7:0] a8, b8, res;
  logic [4:0] sum;

  assign a8  = {4'b0, a};
  assign b8  = {4'b0, b};
  assign sum = {1'b0, a} + {1'b0, b};

  always_comb begin
    res = '0;
    case (opcode)
      OP_OR_RED:  res = {7'b0, |a};
      OP_AND_RED: res = {7'b0, &a};
      OP_XOR_RED: res = {7'b0, ^a};
      OP_LNOT:    res = {7'b0, ~|a};
      OP_ADD:     res = {3'b0, sum};
      OP_MINUS:   res = {4'b0, a - b};
      OP_MUL:     res = a8 * b8;
      OP_SHR:     res = a8 >> b;
      // 8-bit shift: amounts of 8 and above naturally yield zero
      OP_SHL:     res = a8 << b;
      OP_EQ:      res = {7'b0, a == b};
      OP_GT:      res = {7'b0, a > b};
      OP_LT:      res = {7'b0, a < b};
      OP_OR:      res = {4'b0, a | b};
      OP_AND:     res = {4'b0, a & b};
      OP_XOR:     res = {4'b0, a ^ b};
      OP_NOT_OP:  res = {4'b0, ~a};
      default:    res = '0;
    endcase
  end

  assign x = res[3:0];
  assign y = res[7:4];
endmodule

// File: rtl/alu_share_ctrl.sv
// alu_share_ctrl: round-robin time-sharing of one ALU among NREQ requesters.
//   clk, rst_n                      : clock, async active-low reset
//   req_valid/req_ready             : per-requester request handshake
//   req_opcode/req_a/req_b          : flattened 4-bit fields, requester i at [4i+3:4i]
//   rsp_valid/rsp_ready             : one-hot response handshake (owner only)
//   rsp_x/rsp_y                     : registered result nibbles
//   busy                            : FSM outside IDLE
//   op_count                        : completed responses, wrapping
module alu_share_ctrl
  import alu_pkg::*;
#(
  parameter int NREQ  = 2,
  parameter int CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [4*NREQ-1:0]    req_opcode,
  input  logic [4*NREQ-1:0]    req_a,
  input  logic [4*NREQ-1:0]    req_b,
  output logic [NREQ-1:0]      rsp_valid,
  input  logic [NREQ-1:0]      rsp_ready,
  output logic [3:0]           rsp_x,
  output logic [3:0]           rsp_y,
  output logic                 busy,
  output logic [CNT_W-1:0]     op_count
);
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  state_e          state_q;
  logic [IW-1:0]   rr_q, gnt_q, gnt_d;
  logic            gnt_vld;
  logic [3:0]      op_q, a_q, b_q, x_q, y_q, alu_x, alu_y;
  logic [NREQ-1:0] rsp_valid_q;
  logic [CNT_W-1:0] cnt_q;

  // First valid requester at or after rr_q, wrapping. Scanning from the
  // farthest offset down lets the nearest one win.
  always_comb begin
    gnt_d   = '0;
    gnt_vld = 1'b0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      int idx;
      idx = int'(rr_q) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (req_valid[idx]) begin
        gnt_d   = IW'(idx);
        gnt_vld = 1'b1;
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (state_q == ST_IDLE && gnt_vld) req_ready[gnt_d] = 1'b1;
  end

  alu_datapath u_dp (
    .opcode (op_q),
    .a      (a_q),
    .b      (b_q),
    .x      (alu_x),
    .y      (alu_y)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      rr_q        <= '0;
      gnt_q       <= '0;
      op_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      x_q         <= '0;
      y_q         <= '0;
      rsp_valid_q <= '0;
      cnt_q       <= '0;
    end else begin
      case (state_q)
        ST_IDLE: if (gnt_vld) begin
          gnt_q   <= gnt_d;
          op_q    <= req_opcode[{gnt_d, 2'b00} +: 4];
          a_q     <= req_a[{gnt_d, 2'b00} +: 4];
          b_q     <= req_b[{gnt_d, 2'b00} +: 4];
          state_q <= ST_EXEC;
        end
        ST_EXEC: begin
          x_q                <= alu_x;
          y_q                <= alu_y;
          rsp_valid_q        <= '0;
          rsp_valid_q[gnt_q] <= 1'b1;
          state_q            <= ST_RESP;
        end
        ST_RESP: if (rsp_ready[gnt_q]) begin
          rsp_valid_q <= '0;
          cnt_q       <= cnt_q + 1'b1;
          rr_q        <= (gnt_q == IW'(NREQ - 1)) ? '0 : gnt_q + 1'b1;
          state_q     <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_x     = x_q;
  assign rsp_y     = y_q;
  assign busy      = (state_q != ST_IDLE);
  assign op_count  = cnt_q;
endmodule

// File: tb/tb_alu_share_ctrl.sv
// tb_alu_share_ctrl: directed bench with a transaction-level model checked
// every cycle, plus literal expectations for each directed operation.
module tb_alu_share_ctrl;
  import alu_pkg::*;
  localparam int NREQ = 2;
  localparam int CNT_W = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [NREQ-1:0]   req_valid = '0, req_ready, rsp_valid, rsp_ready = '0;
  logic [4*NREQ-1:0] req_opcode = '0, req_a = '0, req_b = '0;
  logic [3:0]        rsp_x, rsp_y;
  logic              busy;
  logic [CNT_W-1:0]  op_count;

  int total = 0;
  int bad = 0;

  alu_share_ctrl #(.NREQ(NREQ), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_opcode(req_opcode), .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_x(rsp_x), .rsp_y(rsp_y), .busy(busy), .op_count(op_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Result {y,x} straight from the opcode table, using integer arithmetic.
  function automatic logic [7:0] exp_alu(input int op, input int a, input int b);
    int r;
    case (op)
      0:  r = (a != 0) ? 1 : 0;
      1:  r = (a == 15) ? 1 : 0;
      2:  r = $countones(a) % 2;
      3:  r = (a == 0) ? 1 : 0;
      4:  r = a + b;
      5:  r = (a - b + 16) % 16;
      6:  r = a * b;
      7:  r = a >> b;
      8:  r = (a << b) % 256;
      9:  r = (a == b) ? 1 : 0;
      10: r = (a > b) ? 1 : 0;
      11: r = (a < b) ? 1 : 0;
      12: r = a | b;
      13: r = a & b;
      14: r = a ^ b;
      default: r = 15 - a;
    endcase
    return r[7:0];
  endfunction

  // Transaction model: one op outstanding at most, response two cycles
  // after acceptance, round-robin pointer moves past the completed owner.
  bit         m_q = 0;
  int         m_owner = 0, m_age = 0, m_cnt = 0, m_rr = 0;
  logic [7:0] m_exp = '0;

  always @(negedge clk) begin : cmp
    logic [NREQ-1:0] e_rdy, e_rv;
    int g, i;
    if (!rst_n) begin
      chk("rst_req_ready", 32'(req_ready), 32'd0);
      chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rst_rsp_xy", {24'd0, rsp_y, rsp_x}, 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_op_count", 32'(op_count), 32'd0);
      m_q = 0; m_cnt = 0; m_rr = 0;
    end else begin
      e_rdy = '0; e_rv = '0; g = -1;
      if (!m_q)
        for (int k = 0; k < NREQ; k++) begin
          i = (m_rr + k) % NREQ;
          if (g < 0 && req_valid[i]) g = i;
        end
      if (g >= 0) e_rdy[g] = 1'b1;
      if (m_q && m_age >= 2) e_rv[m_owner] = 1'b1;
      chk("model_req_ready", 32'(req_ready), 32'(e_rdy));
      chk("model_rsp_valid", 32'(rsp_valid), 32'(e_rv));
      chk("model_busy", 32'(busy), 32'(m_q));
      chk("model_op_count", 32'(op_count), 32'(m_cnt % 65536));
      if (m_q && m_age >= 2) chk("model_rsp_xy", {24'd0, rsp_y, rsp_x}, {24'd0, m_exp});
      if (m_q && m_age >= 2 && rsp_ready[m_owner]) begin
        m_q = 0; m_cnt++; m_rr = (m_owner + 1) % NREQ;
      end else if (m_q) begin
        m_age++;
      end else if (g >= 0) begin
        m_q = 1; m_owner = g; m_age = 1;
        m_exp = exp_alu(int'(req_opcode[g*4 +: 4]), int'(req_a[g*4 +: 4]), int'(req_b[g*4 +: 4]));
      end
    end
  end

  // One operation on requester r; rsp_ready held low for 'hold' response
  // cycles. Ends on the negedge after the response has completed.
  task automatic do_op(input int r, input logic [3:0] op, input logic [3:0] a,
                       input logic [3:0] b, input int hold,
                       input logic [3:0] ex, input logic [3:0] ey);
    int c, lat;
    @(posedge clk); #1;
    req_opcode[r*4 +: 4] = op; req_a[r*4 +: 4] = a; req_b[r*4 +: 4] = b;
    req_valid[r] = 1'b1;
    rsp_ready[r] = (hold == 0);
    c = 0;
    do begin @(negedge clk); c++; end while (!req_ready[r] && c < 20);
    chk("accept_seen", 32'(req_ready[r]), 32'd1);
    @(posedge clk); #1; req_valid[r] = 1'b0;
    lat = 1;
    @(negedge clk);
    while (!rsp_valid[r] && lat < 20) begin @(negedge clk); lat++; end
    chk("latency", 32'(lat), 32'd2);
    chk("rsp_x", 32'(rsp_x), 32'(ex));
    chk("rsp_y", 32'(rsp_y), 32'(ey));
    for (int h = 1; h < hold; h++) begin
      @(negedge clk);
      chk("hold_valid", 32'(rsp_valid[r]), 32'd1);
      chk("hold_xy", {24'd0, rsp_y, rsp_x}, {24'd0, ey, ex});
      chk("hold_req_ready", 32'(req_ready), 32'd0);
    end
    if (hold > 0) begin
      @(posedge clk); #1; rsp_ready[r] = 1'b1;
      @(negedge clk);
      chk("handshake_valid", 32'(rsp_valid[r]), 32'd1);
    end
    @(posedge clk); #1; rsp_ready[r] = 1'b0;
    @(negedge clk);
    chk("rsp_cleared", 32'(rsp_valid[r]), 32'd0);
  endtask

  task automatic pulse_reset();
    @(posedge clk); #1; rst_n = 1'b0;
    @(negedge clk);
    chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_op_count", 32'(op_count), 32'd0);
    @(posedge clk); #1; rst_n = 1'b1;
  endtask

  initial begin
    int c, ngr;
    logic gr [8];

    // Model pins
    chk("pin_add", 32'(exp_alu(4, 9, 8)), 32'h11);
    chk("pin_mul", 32'(exp_alu(6, 15, 15)), 32'hE1);
    chk("pin_shl", 32'(exp_alu(8, 15, 6)), 32'hC0);
    chk("pin_minus", 32'(exp_alu(5, 2, 5)), 32'h0D);

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("post_reset_busy", 32'(busy), 32'd0);
    chk("post_reset_cnt", 32'(op_count), 32'd0);
    chk("post_reset_xy", {24'd0, rsp_y, rsp_x}, 32'd0);

    do_op(0, OP_ADD, 4'd9, 4'd8, 0, 4'h1, 4'h1);
    chk("cnt_after_add", 32'(op_count), 32'd1);
    do_op(1, OP_MUL, 4'hF, 4'hF, 0, 4'h1, 4'hE);
    do_op(1, OP_SHL, 4'hF, 4'd6, 0, 4'h0, 4'hC);
    do_op(1, OP_SHL, 4'hF, 4'd9, 0, 4'h0, 4'h0);
    do_op(0, OP_MINUS, 4'd2, 4'd5, 5, 4'hD, 4'h0);
    do_op(0, OP_EQ, 4'd7, 4'd7, 0, 4'h1, 4'h0);
    do_op(1, OP_GT, 4'd3, 4'd9, 0, 4'h0, 4'h0);
    do_op(0, OP_AND_RED, 4'hF, 4'h0, 0, 4'h1, 4'h0);
    chk("cnt_after_directed", 32'(op_count), 32'd8);

    // Both requesters contend continuously: grants must alternate.
    pulse_reset();
    req_opcode = {OP_XOR, OP_ADD}; req_a = {4'd5, 4'd3}; req_b = {4'd3, 4'd4};
    rsp_ready = 2'b11; req_valid = 2'b11;
    ngr = 0; c = 0;
    while (ngr < 8 && c < 100) begin
      @(negedge clk); c++;
      if (|req_ready) begin gr[ngr] = req_ready[1]; ngr++; end
    end
    @(posedge clk); #1; req_valid = '0;
    c = 0;
    while (op_count != 16'd8 && c < 20) begin @(negedge clk); c++; end
    chk("rr_op_count", 32'(op_count), 32'd8);
    chk("rr_grants", 32'(ngr), 32'd8);
    for (int k = 0; k < 8; k++) chk("rr_order", 32'(gr[k]), 32'(k % 2));
    @(posedge clk); #1; rsp_ready = '0;

    // Reset while a response is waiting.
    @(posedge clk); #1;
    req_opcode[3:0] = OP_OR; req_a[3:0] = 4'h5; req_b[3:0] = 4'hA; req_valid[0] = 1'b1;
    c = 0;
    do begin @(negedge clk); c++; end while (!req_ready[0] && c < 20);
    @(posedge clk); #1; req_valid[0] = 1'b0;
    c = 0;
    do begin @(negedge clk); c++; end while (!rsp_valid[0] && c < 20);
    chk("pre_reset_resp", 32'(rsp_valid), 32'd1);
    pulse_reset();
    @(posedge clk); #1; req_valid = 2'b11; rsp_ready = 2'b11;
    @(negedge clk);
    chk("rr_ptr_reset_grant", 32'(req_ready), 32'd1);
    @(posedge clk); #1; req_valid = '0;
    c = 0;
    while (op_count != 16'd1 && c < 20) begin @(negedge clk); c++; end
    chk("cnt_after_reset_op", 32'(op_count), 32'd1);
    @(posedge clk); #1; rsp_ready = '0;
    do_op(1, OP_NOT_OP, 4'h5, 4'h0, 0, 4'hA, 4'h0);
    chk("cnt_final", 32'(op_count), 32'd2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
